// File: rtl/pueo_dout_pkg.sv
// Shared types and helpers for the PUEO readout byte-stream receiver.
// FSM encoding, error bit positions, event size helper.
package pueo_dout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FLUSH,
    LONGCHK,
    SKIP
  } state_t;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_SHORT    = 1;
  localparam int ERR_LONG     = 2;
  localparam int ERR_OVF      = 3;
  localparam int ERR_MSB      = 4;

  function automatic int event_words(input int nchan, input int nsamp);
    return nchan * nsamp / 2;
  endfunction

endpackage

// File: rtl/pueo_dout_byte_pack.sv
// Byte -> 16-bit sample -> 32-bit word packer with phase-alternation check.
// Also exposes the zero-padded partial word for short-event flushes.
module pueo_dout_byte_pack (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  input  logic        i_phase,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  output logic        o_misalign,
  output logic        o_msb,
  output logic        o_partial,
  output logic [31:0] o_pad_word
);

  logic        r_exp;
  logic        r_half;
  logic [7:0]  r_lo;
  logic [15:0] r_low16;

  logic        w_acc;
  logic [15:0] w_sample;
  logic [15:0] w_pend;

  assign o_misalign   = i_en && (i_phase != r_exp);
  assign w_acc        = i_en && !o_misalign;
  assign w_sample     = {i_byte, r_lo};
  assign o_msb        = w_acc && i_phase && (w_sample[15:12] != 4'h0);
  assign o_word_valid = w_acc && i_phase && r_half;
  assign o_word       = {w_sample, r_low16};
  assign o_partial    = r_exp || r_half;

  // r_exp high means a low byte is held without its high byte
  assign w_pend     = r_exp ? {8'h00, r_lo} : 16'h0000;
  assign o_pad_word = r_half ? {w_pend, r_low16} : {16'h0000, w_pend};

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clear) begin
      r_exp   <= 1'b0;
      r_half  <= 1'b0;
      r_lo    <= '0;
      r_low16 <= '0;
    end else if (w_acc) begin
      if (!i_phase) begin
        r_lo  <= i_byte;
        r_exp <= 1'b1;
      end else begin
        r_exp  <= 1'b0;
        r_half <= !r_half;
        if (!r_half) r_low16 <= w_sample;
      end
    end
  end

endmodule

// File: rtl/pueo_dout_rx.sv
// SURF readout byte stream to AXI4-Stream event packets, with error flags.
// Optional PUEO_DOUT_RX_STATS_EN adds saturating event/error counters.
module pueo_dout_rx
  import pueo_dout_pkg::*;
#(
  parameter  int NCHAN       = 8,
  parameter  int NSAMP       = 1024,
  parameter  int CHECK_MSB   = 1,
  localparam int EVENT_WORDS = event_words(NCHAN, NSAMP),
  localparam int WCW         = $clog2(EVENT_WORDS)
) (
  input  logic        ifclk_i,
  input  logic        ifclk_rstn_i,
  input  logic [7:0]  dout_data_i,
  input  logic        dout_data_valid_i,
  input  logic        dout_data_phase_i,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [4:0]  err_o,
  output logic        busy_o
`ifdef PUEO_DOUT_RX_STATS_EN
  ,
  output logic [31:0] evt_count_o,
  output logic [15:0] err_count_o
`endif
);

  logic [7:0]     r_data;
  logic           r_valid;
  logic           r_phase;
  logic           r_valid_d;
  state_t         r_state;
  logic [WCW-1:0] r_wcnt;
  logic           r_long;
  logic [31:0]    r_tdata;
  logic           r_tvalid;
  logic           r_tlast;
  logic           r_tuser;
  logic [4:0]     r_err;

  state_t         w_next;
  logic [WCW-1:0] w_wcnt;
  logic           w_long;
  logic           w_load;
  logic [31:0]    w_ld_data;
  logic           w_ld_last;
  logic           w_ld_user;
  logic [4:0]     w_err;

  logic           w_rise;
  logic           w_free;
  logic           w_is_last;
  logic           w_pk_en;
  logic           w_pk_clr;
  logic [31:0]    w_pk_word;
  logic           w_pk_wv;
  logic           w_pk_mis;
  logic           w_pk_msb;
  logic           w_pk_partial;
  logic [31:0]    w_pk_pad;

  assign w_rise    = r_valid && !r_valid_d;
  assign w_free    = !r_tvalid || m_axis_tready;
  assign w_is_last = (r_wcnt == WCW'(EVENT_WORDS - 1));

  assign w_pk_en = ((r_state == IDLE) && w_rise && !r_phase)
                || ((r_state == RUN) && r_valid);

  // FLUSH keeps the partial data until the final word is loaded
  assign w_pk_clr = ((r_state == IDLE) && !w_pk_en)
                 || (r_state == SKIP)
                 || (r_state == LONGCHK)
                 || ((r_state == FLUSH) && w_free);

  pueo_dout_byte_pack u_pack (
    .i_clk        (ifclk_i),
    .i_rstn       (ifclk_rstn_i),
    .i_clear      (w_pk_clr),
    .i_en         (w_pk_en),
    .i_byte       (r_data),
    .i_phase      (r_phase),
    .o_word       (w_pk_word),
    .o_word_valid (w_pk_wv),
    .o_misalign   (w_pk_mis),
    .o_msb        (w_pk_msb),
    .o_partial    (w_pk_partial),
    .o_pad_word   (w_pk_pad)
  );

  always_comb begin
    w_next    = r_state;
    w_wcnt    = r_wcnt;
    w_long    = r_long;
    w_load    = 1'b0;
    w_ld_data = w_pk_word;
    w_ld_last = 1'b0;
    w_ld_user = 1'b0;
    w_err     = '0;
    unique case (r_state)
      IDLE: begin
        w_wcnt = '0;
        if (w_rise) begin
          if (r_phase) begin
            w_err[ERR_MISALIGN] = 1'b1;
            w_next = SKIP;
          end else begin
            w_next = RUN;
          end
        end
      end
      RUN: begin
        if (w_pk_mis) begin
          w_err[ERR_MISALIGN] = 1'b1;
          w_next = FLUSH;
        end else if (!r_valid) begin
          w_next = FLUSH;
        end else if (w_pk_wv) begin
          w_ld_last = w_is_last;
          // a busy register drops the word but the count still moves
          if (w_free) w_load = 1'b1;
          else w_err[ERR_OVF] = 1'b1;
          if (w_is_last) begin
            w_next = LONGCHK;
            w_long = 1'b0;
          end else begin
            w_wcnt = r_wcnt + 1'b1;
          end
        end
        if ((CHECK_MSB != 0) && w_pk_msb) w_err[ERR_MSB] = 1'b1;
      end
      FLUSH: begin
        if (w_free) begin
          w_load    = 1'b1;
          w_ld_data = w_pk_partial ? w_pk_pad : 32'h0;
          w_ld_last = 1'b1;
          w_ld_user = 1'b1;
          w_err[ERR_SHORT] = 1'b1;
          w_next = r_valid ? SKIP : IDLE;
        end
      end
      LONGCHK: begin
        if (!r_valid) begin
          w_next = IDLE;
        end else if (!r_long) begin
          w_err[ERR_LONG] = 1'b1;
          w_long = 1'b1;
        end
      end
      SKIP: begin
        if (!r_valid) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge ifclk_i) begin
    if (!ifclk_rstn_i) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_phase   <= 1'b0;
      r_valid_d <= 1'b0;
      r_state   <= IDLE;
      r_wcnt    <= '0;
      r_long    <= 1'b0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tuser   <= 1'b0;
      r_err     <= '0;
    end else begin
      r_data    <= dout_data_i;
      r_valid   <= dout_data_valid_i;
      r_phase   <= dout_data_phase_i;
      r_valid_d <= r_valid;
      r_state   <= w_next;
      r_wcnt    <= w_wcnt;
      r_long    <= w_long;
      r_err     <= w_err;
      if (w_load) begin
        r_tdata  <= w_ld_data;
        r_tlast  <= w_ld_last;
        r_tuser  <= w_ld_user;
        r_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign err_o         = r_err;
  assign busy_o        = (r_state == RUN) || (r_state == FLUSH);

`ifdef PUEO_DOUT_RX_STATS_EN
  logic [31:0] r_evt_cnt;
  logic [15:0] r_err_cnt;
  logic        w_evt_done;

  assign w_evt_done = (r_state == RUN) && w_pk_wv && w_is_last;

  always_ff @(posedge ifclk_i) begin
    if (!ifclk_rstn_i) begin
      r_evt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_evt_done && (r_evt_cnt != '1)) r_evt_cnt <= r_evt_cnt + 1'b1;
      if ((|w_err) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign evt_count_o = r_evt_cnt;
  assign err_count_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_pueo_dout_rx.sv
// Bench for pueo_dout_rx: directed vector table, reset corner, random events.
// Expected words come from a byte-list model of the event rules.
`timescale 1ns/1ps
module tb_pueo_dout_rx;

  localparam int NCHAN = 8;
  localparam int NSAMP = 4;
  localparam int EW    = NCHAN * NSAMP / 2;
  localparam int GAP   = 14;

  typedef struct {
    logic [31:0] d;
    bit          l;
    bit          u;
  } word_t;

  typedef struct {
    string nm;
    int    n;
    bit    bad;
    int    gl;
    int    sa;
    int    sl;
    int    ew;
    int    e0;
    int    e1;
    int    e2;
    int    e3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  din = '0;
  logic        dval = 1'b0;
  logic        dph = 1'b0;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic        tuser;
  logic [4:0]  err;
  logic        busy;

  always #5 clk = ~clk;

  pueo_dout_rx #(
    .NCHAN     (NCHAN),
    .NSAMP     (NSAMP),
    .CHECK_MSB (1)
  ) dut (
    .ifclk_i           (clk),
    .ifclk_rstn_i      (rstn),
    .dout_data_i       (din),
    .dout_data_valid_i (dval),
    .dout_data_phase_i (dph),
    .m_axis_tdata      (tdata),
    .m_axis_tvalid     (tvalid),
    .m_axis_tready     (tready),
    .m_axis_tlast      (tlast),
    .m_axis_tuser      (tuser),
    .err_o             (err),
    .busy_o            (busy)
  );

  int    nchk = 0;
  int    nfail = 0;
  int    ecnt [5];
  int    got = 0;
  int    nlast = 0;
  int    drops = 0;
  word_t exp_q [$];
  logic [7:0] ev_b [0:127];
  bit         ev_p [0:127];
  int    m_words;
  int    m_err [5];
  int    d_got;
  int    d_err [5];

  task automatic chk(input string nm, input int act, input int req);
    nchk++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  // output monitor / scoreboard; an err_o[3] pulse licenses one skipped word
  initial begin : mon
    bit          held;
    logic [33:0] hold_v;
    word_t       w;
    held = 1'b0;
    hold_v = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        held = 1'b0;
      end else begin
        for (int k = 0; k < 5; k++) if (err[k]) ecnt[k]++;
        if (err[3]) drops++;
        if (held) begin
          nchk++;
          if (!tvalid || ({tdata, tlast, tuser} != hold_v)) begin
            nfail++;
            $display("FAIL hold: got v=%0b %h/%0b/%0b want %h/%0b/%0b",
                     tvalid, tdata, tlast, tuser,
                     hold_v[33:2], hold_v[1], hold_v[0]);
          end
        end
        if (tvalid && tready) begin
          got++;
          if (tlast) nlast++;
          while (drops > 0 && exp_q.size() > 0 && exp_q[0].d != tdata) begin
            w = exp_q.pop_front();
            drops--;
          end
          nchk++;
          if (exp_q.size() == 0) begin
            nfail++;
            $display("FAIL extra word: got %h, want none", tdata);
          end else begin
            w = exp_q.pop_front();
            if (w.d != tdata || w.l != tlast || w.u != tuser) begin
              nfail++;
              $display("FAIL word: got %h/%0b/%0b want %h/%0b/%0b",
                       tdata, tlast, tuser, w.d, w.l, w.u);
            end
          end
        end
        held = tvalid && !tready;
        hold_v = {tdata, tlast, tuser};
      end
    end
  end

  task automatic fill(input int n, input bit rnd, input bit bad, input int gl);
    for (int i = 0; i < n; i++) begin
      ev_b[i] = rnd ? 8'($urandom) : (i[0] ? 8'h00 : 8'(i / 2));
      ev_p[i] = i[0] ^ bad ^ ((gl > 0) && (i >= gl));
    end
  endtask

  // event rules applied to a plain byte list
  task automatic model(input int n);
    logic [7:0] acc [$];
    word_t w;
    int nw;
    bit sh;
    nw = 0;
    sh = 1'b0;
    m_words = 0;
    for (int k = 0; k < 5; k++) m_err[k] = 0;
    if (ev_p[0]) begin
      m_err[0] = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (nw == EW) begin
        m_err[2] = 1;
        break;
      end
      if (ev_p[i] != i[0]) begin
        m_err[0]++;
        break;
      end
      acc.push_back(ev_b[i]);
      if (i[0] && ev_b[i][7:4] != 4'h0) m_err[4]++;
      if (acc.size() == 4) begin
        w.d = {acc[3], acc[2], acc[1], acc[0]};
        w.l = (nw == EW - 1);
        w.u = 1'b0;
        exp_q.push_back(w);
        nw++;
        acc.delete();
      end
    end
    if (nw < EW) sh = 1'b1;
    if (sh) begin
      while (acc.size() < 4) acc.push_back(8'h00);
      w.d = {acc[3], acc[2], acc[1], acc[0]};
      w.l = 1'b1;
      w.u = 1'b1;
      exp_q.push_back(w);
      nw++;
      m_err[1]++;
    end
    m_words = nw;
  endtask

  task automatic send(input int n, input int sa, input int sl, input bit rnd);
    int st;
    int zr;
    st = 0;
    zr = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      din = ev_b[i];
      dph = ev_p[i];
      dval = 1'b1;
      if (i == sa) st = sl;
      if (st > 0) begin
        tready = 1'b0;
        st--;
      end else if (rnd && zr < 2 && $urandom_range(0, 3) == 0) begin
        tready = 1'b0;
        zr++;
      end else begin
        tready = 1'b1;
        zr = 0;
      end
    end
    @(posedge clk);
    #1;
    dval = 1'b0;
    din = '0;
    dph = 1'b0;
    tready = 1'b1;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic do_event(input int n, input bit bad, input int gl,
                          input int sa, input int sl, input bit rnd);
    int g0;
    int e0 [5];
    fill(n, rnd, bad, gl);
    model(n);
    g0 = got;
    for (int k = 0; k < 5; k++) e0[k] = ecnt[k];
    send(n, sa, sl, rnd);
    d_got = got - g0;
    for (int k = 0; k < 5; k++) d_err[k] = ecnt[k] - e0[k];
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : wdog
    #1000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tv [10];
    int   l0;
    int   n;
    int   gl;
    bit   bad;
    tv[0] = '{"normal",  64, 1'b0,  0, -1, 0, 16, 0, 0, 0, 0};
    tv[1] = '{"badstart",64, 1'b1,  0, -1, 0,  0, 1, 0, 0, 0};
    tv[2] = '{"realign", 64, 1'b0,  0, -1, 0, 16, 0, 0, 0, 0};
    tv[3] = '{"short21", 21, 1'b0,  0, -1, 0,  6, 0, 1, 0, 0};
    tv[4] = '{"long72",  72, 1'b0,  0, -1, 0, 16, 0, 0, 1, 0};
    tv[5] = '{"stall",   64, 1'b0,  0, 20, 8, 15, 0, 0, 0, 1};
    tv[6] = '{"glitch",  64, 1'b0, 10, -1, 0,  3, 1, 1, 0, 0};
    tv[7] = '{"short8",   8, 1'b0,  0, -1, 0,  3, 0, 1, 0, 0};
    tv[8] = '{"short63", 63, 1'b0,  0, -1, 0, 16, 0, 1, 0, 0};
    tv[9] = '{"single",   1, 1'b0,  0, -1, 0,  1, 0, 1, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst tvalid", int'(tvalid), 0);
    chk("rst tlast", int'(tlast), 0);
    chk("rst tuser", int'(tuser), 0);
    chk("rst tdata", int'(tdata), 0);
    chk("rst err", int'(err), 0);
    chk("rst busy", int'(busy), 0);

    for (int i = 0; i < 10; i++) begin
      do_event(tv[i].n, tv[i].bad, tv[i].gl, tv[i].sa, tv[i].sl, 1'b0);
      chk($sformatf("%s words", tv[i].nm), d_got, tv[i].ew);
      chk($sformatf("%s misalign", tv[i].nm), d_err[0], tv[i].e0);
      chk($sformatf("%s short", tv[i].nm), d_err[1], tv[i].e1);
      chk($sformatf("%s long", tv[i].nm), d_err[2], tv[i].e2);
      chk($sformatf("%s ovf", tv[i].nm), d_err[3], tv[i].e3);
      chk($sformatf("%s msb", tv[i].nm), d_err[4], 0);
    end

    // reset in the middle of an event
    fill(64, 1'b0, 1'b0, 0);
    model(64);
    l0 = nlast;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      din = ev_b[i];
      dph = ev_p[i];
      dval = 1'b1;
    end
    @(negedge clk);
    chk("mid busy", int'(busy), 1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    dval = 1'b0;
    din = '0;
    dph = 1'b0;
    @(negedge clk);
    chk("mid rst tvalid", int'(tvalid), 0);
    chk("mid rst err", int'(err), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    chk("mid rst no tlast", nlast - l0, 0);
    repeat (4) @(posedge clk);
    l0 = nlast;
    do_event(64, 1'b0, 0, -1, 0, 1'b0);
    chk("post rst words", d_got, 16);
    chk("post rst tlast", nlast - l0, 1);

    for (int r = 0; r < 12; r++) begin
      n   = $urandom_range(1, 80);
      bad = ($urandom_range(0, 7) == 0);
      gl  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n) : 0;
      do_event(n, bad, gl, -1, 0, 1'b1);
      chk($sformatf("rnd%0d words", r), d_got, m_words);
      for (int k = 0; k < 5; k++)
        chk($sformatf("rnd%0d err%0d", r, k), d_err[k], m_err[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/pueo_dout_rx.md
Name: pueo_dout_rx

Overview:
- Receiving end of the SURF readout byte stream (dout_data / dout_data_valid / dout_data_phase) in the ifclk domain.
- Pairs bytes into 16-bit samples and samples into 32-bit words, then emits one AXI4-Stream packet per event.
- Checks phase alignment and event length, and flags overflow.
- Used on the TURFIO-side capture path and as a scoreboard front-end in SURF benches.

Parameters:
- NCHAN, 8, channels per event.
- NSAMP, 1024, 16-bit samples per channel per event.
- EVENT_WORDS, NCHAN*NSAMP/2, 32-bit words per event (derived; do not override).
- CHECK_MSB, 1, if 1, any sample with bits [15:12] nonzero raises err_o[4].

Ports:
- ifclk_i  in  1  readout clock (125 MHz); the only clock.
- ifclk_rstn_i  in  1  reset, synchronous, active-low.
- dout_data_i  in  8  stream byte.
- dout_data_valid_i  in  1  high for the whole event.
- dout_data_phase_i  in  1  0 = low byte of sample, 1 = high byte.
- m_axis_tdata  out  32  {sample[2k+1], sample[2k]}.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last word of event.
- m_axis_tuser  out  1  event truncated (valid only with tlast).
- err_o  out  5  one-cycle pulses: [0] misalign, [1] short, [2] long, [3] overflow, [4] msb.
- busy_o  out  1  high while in RUN or FLUSH.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-event discards the partial event (no tlast) and clears tvalid.
- Input register stage: data, valid and phase are registered once.
- IDLE:
  - valid rising with phase=0 -> RUN.
  - valid rising with phase=1 -> err_o[0], go to SKIP.
- SKIP: ignore bytes until valid=0, then IDLE.
- RUN byte assembly:
  - phase-0 byte -> low byte of sample.
  - phase-1 byte -> high byte; the sample completes.
  - An even sample index fills tdata[15:0]; an odd index fills [31:16] and completes a word.
  - A completed word loads the output register. tvalid rises 2 cycles after the phase-1 byte is presented.
- Word counter wcnt, 0..EVENT_WORDS-1:
  - tlast=1 on the word with wcnt==EVENT_WORDS-1, with tuser=0; then go to LONGCHK.
- LONGCHK:
  - valid falls -> IDLE.
  - any further valid byte -> err_o[2] once, and bytes are discarded until valid=0.
- Short event (valid falls in RUN before EVENT_WORDS words) -> FLUSH:
  - Emit one final word with tlast=1, tuser=1.
  - Missing bytes and samples are zero-padded. If no partial data remains, emit a zero word.
  - Raise err_o[1], then IDLE.
- Phase error inside RUN: two consecutive bytes with the same phase -> err_o[0]. The event is treated as short at that point: FLUSH, then SKIP.
- Handshake:
  - Standard AXIS. tdata, tlast and tuser are stable while tvalid && !tready. tvalid drops after an accept if no new word is pending.
  - A word completes at most once every 4 cycles, so a single output register suffices.
  - If a new word completes while tvalid && !tready: the new word is dropped, err_o[3] pulses, wcnt still advances, and tlast/tuser placement is unchanged.
  - In FLUSH, the final word waits for the register to free; it is never dropped.
- Simultaneous valid fall and phase-1 byte: the byte is accepted first, then short/tlast is evaluated.
- wcnt width: $clog2(EVENT_WORDS). It never wraps; the LONGCHK state prevents wraparound.

Optional Feature:
- PUEO_DOUT_RX_STATS_EN:
  - Defined: adds outputs evt_count_o[31:0] (complete events, tuser=0) and err_count_o[15:0] (any err_o bit set). Both saturate and clear on reset.
  - Undefined: the ports are absent and no counters are synthesized.

Decomposition:
- Package pueo_dout_pkg holds:
  - state enum (IDLE, RUN, FLUSH, LONGCHK, SKIP);
  - err bit index constants ERR_MISALIGN=0 .. ERR_MSB=4;
  - function event_words(nchan, nsamp).
- One sub-module, pueo_dout_byte_pack: byte-to-sample-to-word packing plus phase check. It outputs word, word_valid and partial flags; the top-level holds the FSM and the AXIS register.

Test Plan:
- Use NSAMP=4 (EVENT_WORDS=16). Send 64 bytes with phase alternating 0/1, samples 0x0000..0x001F, tready=1 -> 16 words, first 0x00010000, last 0x001F001E with tlast=1, tuser=0, err_o=0.
- Same event, first byte on phase=1 -> err_o[0] once, zero words output, next aligned event received intact.
- Valid drops after 21 bytes -> 5 normal words, then 6th word 0x000000AA (where AA is byte 21) with tlast=1, tuser=1, err_o[1].
- 72 bytes -> 16 words with tlast on word 16, err_o[2] once, no extra words.
- tready=0 for 8 cycles mid-event -> err_o[3]=1 for the dropped word, tlast still on 16th count, held word unchanged while stalled.
- Reset asserted at byte 30 -> tvalid=0 next cycle, no tlast, next event output exactly 16 words.
